// File: rtl/axi_lite_mem_slave.sv
// AXI-lite style word memory responder with independent read/write FSMs
// and a side debug port for preload and inspection.
module axi_lite_mem_slave #(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 0,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_t;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_RESP
  } wstate_t;

  logic [31:0] r_mem [DEPTH];

  rstate_t     r_rstate;
  wstate_t     r_wstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_araddr;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [31:0] r_awaddr;
  logic [7:0]  r_err;

  logic [31:0] w_ar_off;
  logic [31:0] w_aw_off;
  logic        w_ar_ok;
  logic        w_aw_ok;
  logic [AW-1:0] w_ar_idx;
  logic [AW-1:0] w_aw_idx;
  logic [AW-1:0] w_dbg_idx;
  logic        w_rd_sample;
  logic        w_w_hs;
  logic        w_rd_rej;
  logic        w_wr_rej;
  logic        w_wr_commit;
  logic [8:0]  w_err_sum;
  logic        w_dbg_unused;

  assign w_ar_off = r_araddr - BASE_ADDR;
  assign w_aw_off = r_awaddr - BASE_ADDR;
  assign w_ar_idx = w_ar_off[AW+1:2];
  assign w_aw_idx = w_aw_off[AW+1:2];

  assign w_ar_ok = (r_araddr[1:0] == 2'b00) &&
                   (r_araddr >= BASE_ADDR) &&
                   (w_ar_off[31:2] < DEPTH_W);
  assign w_aw_ok = (r_awaddr[1:0] == 2'b00) &&
                   (r_awaddr >= BASE_ADDR) &&
                   (w_aw_off[31:2] < DEPTH_W);

  assign w_rd_sample = (r_rstate == R_WAIT) &&
                       (r_cnt == 4'd0);
  assign w_w_hs      = (r_wstate == W_DATA) &&
                       WVALID && r_wready;
  assign w_rd_rej    = w_rd_sample && !w_ar_ok;
  assign w_wr_rej    = w_w_hs && !w_aw_ok;
  assign w_wr_commit = w_w_hs && w_aw_ok && !reset;

  assign w_err_sum = {1'b0, r_err} +
                     {8'd0, w_rd_rej} +
                     {8'd0, w_wr_rej};

  assign w_dbg_idx    = dbg_addr[AW-1:0];
  assign w_dbg_unused = ^dbg_addr;
  assign dbg_rdata    = r_mem[w_dbg_idx];

  assign ARREADY   = r_arready;
  assign RVALID    = r_rvalid;
  assign RDATA     = r_rdata;
  assign AWREADY   = r_awready;
  assign WREADY    = r_wready;
  assign BVALID    = r_bvalid;
  assign err_count = r_err;

  // Debug write is placed last so it wins over a same-word bus write.
  always_ff @(posedge clk) begin
    if (w_wr_commit)
      r_mem[w_aw_idx] <= WDATA;
    if (dbg_we)
      r_mem[w_dbg_idx] <= dbg_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_cnt     <= 4'd0;
      r_araddr  <= 32'd0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (!r_arready) begin
            r_arready <= 1'b1;
          end else if (ARVALID) begin
            r_araddr  <= ARADDR;
            r_arready <= 1'b0;
            r_cnt     <= 4'(READ_LATENCY);
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata  <= w_ar_ok ? r_mem[w_ar_idx]
                                : ERR_DATA;
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_ADDR;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awaddr  <= 32'd0;
    end else begin
      unique case (r_wstate)
        W_ADDR: begin
          if (!r_awready) begin
            r_awready <= 1'b1;
          end else if (AWVALID) begin
            r_awaddr  <= AWADDR;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_ADDR;
          end
        end
        default: r_wstate <= W_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 8'd0;
    else if (w_err_sum[8])
      r_err <= 8'hFF;
    else
      r_err <= w_err_sum[7:0];
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench: latency-0 instance for bus/debug/error paths,
// latency-3 instance for read wait and back-pressure.
module tb_axi_lite_mem_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] araddr = 0, rdata;
  logic        awvalid = 0, awready, wvalid = 0, wready;
  logic        bvalid, bready = 0;
  logic [31:0] awaddr = 0, wdata = 0;
  logic        dbg_we = 0;
  logic [7:0]  dbg_addr = 0, err_count;
  logic [31:0] dbg_wdata = 0, dbg_rdata;

  logic        arvalid3 = 0, arready3, rvalid3, rready3 = 0;
  logic [31:0] araddr3 = 0, rdata3;
  logic        awready3, wready3, bvalid3;
  logic        dbg_we3 = 0;
  logic [7:0]  dbg_addr3 = 0, err_count3;
  logic [31:0] dbg_wdata3 = 0, dbg_rdata3;

  int n_checks = 0;
  int n_fail = 0;

  axi_lite_mem_slave u_dut (
    .clk(clk), .reset(reset),
    .ARVALID(arvalid), .ARREADY(arready),
    .ARADDR(araddr), .RVALID(rvalid),
    .RREADY(rready), .RDATA(rdata),
    .AWVALID(awvalid), .AWREADY(awready),
    .AWADDR(awaddr), .WVALID(wvalid),
    .WREADY(wready), .WDATA(wdata),
    .BVALID(bvalid), .BREADY(bready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .err_count(err_count)
  );

  axi_lite_mem_slave #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .ARVALID(arvalid3), .ARREADY(arready3),
    .ARADDR(araddr3), .RVALID(rvalid3),
    .RREADY(rready3), .RDATA(rdata3),
    .AWVALID(1'b0), .AWREADY(awready3),
    .AWADDR(32'd0), .WVALID(1'b0),
    .WREADY(wready3), .WDATA(32'd0),
    .BVALID(bvalid3), .BREADY(1'b0),
    .dbg_we(dbg_we3), .dbg_addr(dbg_addr3),
    .dbg_wdata(dbg_wdata3), .dbg_rdata(dbg_rdata3),
    .err_count(err_count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_hi(input string tag,
                         ref logic sig);
    int k;
    k = 0;
    while (sig !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic dbg_wr(input logic [7:0] a,
                        input logic [31:0] d);
    dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 0;
  endtask

  task automatic axi_read(input logic [31:0] a,
                          output logic [31:0] d);
    arvalid = 1; araddr = a; rready = 1;
    wait_hi("ar", arready);
    tick();
    arvalid = 0;
    wait_hi("r", rvalid);
    d = rdata;
    tick();
  endtask

  task automatic axi_write(input logic [31:0] a,
                           input logic [31:0] d);
    awvalid = 1; awaddr = a;
    wait_hi("aw", awready);
    tick();
    awvalid = 0; wvalid = 1; wdata = d;
    wait_hi("w", wready);
    tick();
    wvalid = 0; bready = 1;
    wait_hi("b", bvalid);
    tick();
    bready = 0;
  endtask

  logic [31:0] rd;

  initial begin
    tick();
    tick();
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err_count, 0);
    reset = 0;
    tick();
    check("arready_up", arready, 1);
    check("awready_up", awready, 1);

    dbg_wr(0, 32'h11);
    dbg_wr(1, 32'h22);
    dbg_wr(2, 32'h33);
    dbg_wr(3, 32'h44);
    dbg_addr = 2; #1;
    check("dbg_rd2", dbg_rdata, 32'h33);

    // Read 0x8 at latency 0
    arvalid = 1; araddr = 32'h8; rready = 1;
    tick();
    arvalid = 0; araddr = 32'hC;
    check("rd_arready_lo", arready, 0);
    check("rd_rvalid_lo", rvalid, 0);
    tick();
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, 32'h33);
    tick();
    check("rd_rvalid_end", rvalid, 0);
    check("rd_arready_back", arready, 1);

    // Write 0x4 with BREADY held low
    awvalid = 1; awaddr = 32'h4;
    tick();
    awvalid = 0; awaddr = 32'h0;
    check("wr_awready_lo", awready, 0);
    check("wr_wready", wready, 1);
    wvalid = 1; wdata = 32'hCAFE_F00D;
    tick();
    wvalid = 0; wdata = 32'h0;
    check("wr_wready_lo", wready, 0);
    check("wr_bvalid", bvalid, 1);
    dbg_addr = 1; #1;
    check("wr_mem1", dbg_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_bvalid_hold", bvalid, 1);
    end
    bready = 1;
    tick();
    bready = 0;
    check("wr_bvalid_end", bvalid, 0);
    check("wr_awready_back", awready, 1);

    // Latency-3 instance with RREADY back-pressure
    dbg_wr3_blk: begin
      dbg_we3 = 1; dbg_addr3 = 5;
      dbg_wdata3 = 32'hA5A5_0005;
      tick();
      dbg_we3 = 0;
    end
    arvalid3 = 1; araddr3 = 32'h14;
    tick();
    arvalid3 = 0;
    tick();
    tick();
    tick();
    check("l3_rvalid_n3", rvalid3, 0);
    tick();
    check("l3_rvalid_n4", rvalid3, 1);
    check("l3_rdata", rdata3, 32'hA5A5_0005);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("l3_rvalid_hold", rvalid3, 1);
      check("l3_rdata_hold", rdata3, 32'hA5A5_0005);
    end
    rready3 = 1;
    tick();
    rready3 = 0;
    check("l3_rvalid_end", rvalid3, 0);
    check("l3_arready_back", arready3, 1);

    // Rejected read then rejected write
    arvalid = 1; araddr = 32'h41;
    tick();
    arvalid = 0;
    tick();
    check("rej_rvalid", rvalid, 1);
    check("rej_rdata", rdata, 32'hDEAD_BEEF);
    check("rej_err1", err_count, 1);
    tick();
    wvalid = 1; wdata = 32'h1234_5678;
    tick();
    check("early_w_wready", wready, 0);
    awvalid = 1; awaddr = 32'h40;
    tick();
    awvalid = 0;
    tick();
    wvalid = 0;
    check("rej_w_bvalid", bvalid, 1);
    check("rej_err2", err_count, 2);
    dbg_addr = 0; #1;
    check("rej_mem0", dbg_rdata, 32'h11);
    bready = 1;
    tick();
    bready = 0;

    // Simultaneous rejected read and write
    arvalid = 1; araddr = 32'h3;
    awvalid = 1; awaddr = 32'h80;
    tick();
    arvalid = 0; awvalid = 0;
    wvalid = 1; wdata = 32'h5555_5555;
    tick();
    wvalid = 0;
    check("dual_err4", err_count, 4);
    check("dual_rvalid", rvalid, 1);
    check("dual_bvalid", bvalid, 1);
    bready = 1;
    tick();
    bready = 0;

    // Bus-driven copy of words 0..3 to byte 0x20
    for (int i = 0; i < 4; i++)
      dbg_wr(8'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(4 * i), rd);
      check("cp_rd", rd, 32'(i + 1));
      axi_write(32'h20 + 32'(4 * i), rd);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 8'(8 + i); #1;
      check("cp_dst", dbg_rdata, 32'(i + 1));
    end
    check("cp_err", err_count, 4);

    // Debug write wins over bus write to word 2
    awvalid = 1; awaddr = 32'h8;
    tick();
    awvalid = 0;
    wvalid = 1; wdata = 32'h99;
    dbg_we = 1; dbg_addr = 2; dbg_wdata = 32'h77;
    tick();
    wvalid = 0; dbg_we = 0;
    check("dbg_wins", dbg_rdata, 32'h77);
    bready = 1;
    tick();
    bready = 0;

    // Reset in W_DATA aborts the write
    awvalid = 1; awaddr = 32'h0;
    tick();
    awvalid = 0;
    check("mid_wready", wready, 1);
    wvalid = 1; wdata = 32'hBAD0_BAD0;
    reset = 1;
    tick();
    wvalid = 0;
    check("mid_wready_lo", wready, 0);
    check("mid_awready_lo", awready, 0);
    dbg_addr = 0; #1;
    check("mid_mem0", dbg_rdata, 32'h1);
    reset = 0;
    tick();
    check("mid_awready_up", awready, 1);
    check("mid_err_clr", err_count, 0);
    check("mid_mem0_post", dbg_rdata, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI-lite-style memory responder: the target end of the dma_master read and write channels.
- Serves word reads on AR/R and word writes on AW/W/B from an internal register array.
- Sits behind the DMA as source and destination memory, for system integration and DMA verification.
- Side debug port lets a bench preload and inspect memory without using the bus.

Parameters:
DEPTH, 16, number of 32-bit words (power of 2, 2..256)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
READ_LATENCY, 0, extra wait cycles between AR handshake and RVALID (0..15)
ERR_DATA, 32'hDEAD_BEEF, RDATA returned for a rejected read

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  32  read byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  32  read data
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  32  write byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  32  write data
BVALID  out  1  write response valid
BREADY  in  1  write response ready
dbg_we  in  1  debug write strobe
dbg_addr  in  8  debug word index (bits above log2(DEPTH) ignored)
dbg_wdata  in  32  debug write data
dbg_rdata  out  32  combinational read of mem[dbg_addr]
err_count  out  8  count of rejected accesses, saturating

Behaviour:
- Reset (clk = clk, reset = reset, synchronous, active-high) clears the following:
  - ARREADY, AWREADY, WREADY, RVALID and BVALID go to 0.
  - RDATA and err_count go to 0.
  - FSMs go to R_IDLE / W_ADDR and the latency counter goes to 0.
  - Memory contents are NOT cleared.
- ARREADY and AWREADY rise on the first edge after reset deasserts.
- All bus outputs are registered.
- Handshake occurs on any edge where VALID && READY.
- Address check: accepted iff addr[1:0]==0, addr >= BASE_ADDR, and (addr-BASE_ADDR)>>2 < DEPTH. Word index = (addr-BASE_ADDR)>>2.
- Read FSM:
  - R_IDLE (ARREADY=1): on AR handshake, latch ARADDR, ARREADY<=0, cnt<=READ_LATENCY, go to R_WAIT.
  - R_WAIT: if cnt!=0, cnt<=cnt-1. If cnt==0:
    - RDATA<=mem[idx], or ERR_DATA if rejected.
    - RVALID<=1, go to R_DATA.
  - R_DATA: RVALID and RDATA stay stable until RREADY. On R handshake, RVALID<=0, ARREADY<=1, go to R_IDLE.
  - Latency: AR handshake at edge N gives RVALID=1 after edge N+1+READ_LATENCY. ARREADY returns 1 the edge after the R handshake (one bubble).
- Write FSM:
  - W_ADDR (AWREADY=1): on AW handshake, latch AWADDR, AWREADY<=0, WREADY<=1, go to W_DATA.
  - W_DATA: WVALID before AW is not accepted (WREADY=0 outside W_DATA). On W handshake:
    - mem[idx]<=WDATA if accepted; dropped if rejected.
    - WREADY<=0, BVALID<=1, go to W_RESP.
  - W_RESP: BVALID held until BREADY. On B handshake, BVALID<=0, AWREADY<=1, go to W_ADDR.
  - Minimum write transaction: 3 edges.
- Read and write FSMs are fully independent and may be active in the same cycle.
- Read and write to the same word in the same cycle: the read sample in R_WAIT sees the old value; the write becomes visible the next cycle.
- Debug port:
  - dbg_we writes mem[dbg_addr] at the edge, with no bus interaction.
  - If dbg_we and an AXI write commit hit the same word on the same edge, debug data wins.
- err_count increments by 1 per rejected read (at R_WAIT sample) and per rejected write (at W handshake). It saturates at 255.
- A simultaneous rejected read and rejected write add 2, clamped at 255.
- Input changes while not ready are ignored. ARADDR/AWADDR are sampled only at their handshake.
- Reset mid-transaction aborts both FSMs immediately. Any pending write not yet at W handshake is not performed.

Test Plan:
- Preload via dbg: mem[0..3]=0x11,0x22,0x33,0x44; AR ARADDR=0x8 with RREADY=1, READ_LATENCY=0 -> RVALID after 2 edges, RDATA=0x33, ARREADY back 1 edge later.
- AW 0x4 then W 0xCAFEF00D, BREADY held 0 for 3 cycles -> BVALID held, dbg_rdata at dbg_addr=1 reads 0xCAFEF00D, B completes when BREADY=1.
- READ_LATENCY=3, RREADY=0 for 5 cycles after RVALID -> RVALID at N+4, RDATA stable throughout, completes on RREADY.
- Rejected accesses:
  - read ARADDR=0x41 (DEPTH=16) returns RDATA=0xDEADBEEF.
  - write to BASE_ADDR+0x40 leaves memory unchanged.
  - err_count=2.
- Connect dma_master, length=16, src=0x0, dst=0x20, src words 1..4 -> mem[8..11]=1..4, done pulses once, err_count=0.
- Reset asserted in W_DATA after AW 0x0 -> WREADY=0, mem[0] unchanged, AWREADY=1 one edge after reset release.
